// File: rtl/router_op_lut_event_pacer.sv
// rtl/router_op_lut_event_pacer.sv - paces per-packet event pulses onto the counter updates bus
module router_op_lut_event_pacer #(
  parameter int NUM_EVENTS          = 10,
  parameter int PEND_WIDTH          = 4,
  parameter int MIN_UPDATE_INTERVAL = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic [NUM_EVENTS-1:0] updates_out,
  output logic [NUM_EVENTS-1:0] pend_overflow,
  input  logic                  overflow_clr,
  output logic                  idle
);

  localparam int CNT_W = (MIN_UPDATE_INTERVAL > 2) ? $clog2(MIN_UPDATE_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]      LAST_SLOT = CNT_W'(MIN_UPDATE_INTERVAL - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;

  generate
    if (MIN_UPDATE_INTERVAL < 2) begin : g_bad_interval
      $error("router_op_lut_event_pacer: MIN_UPDATE_INTERVAL must be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0]      slot_cnt;
  logic                  drain;
  logic [PEND_WIDTH-1:0] pend     [NUM_EVENTS];
  logic [PEND_WIDTH-1:0] pend_nxt [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] upd_nxt;
  logic [NUM_EVENTS-1:0] ovf_nxt;
  logic                  idle_nxt;

  assign drain = (slot_cnt == LAST_SLOT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
    end else if (drain) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // A simultaneous arrival and drain cancel out; saturation drops the arrival and flags it.
  always_comb begin
    upd_nxt  = '0;
    ovf_nxt  = overflow_clr ? '0 : pend_overflow;
    idle_nxt = 1'b1;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      pend_nxt[i] = pend[i];
      upd_nxt[i]  = drain && (pend[i] != '0);
      if (event_in[i] && !upd_nxt[i]) begin
        if (pend[i] == PEND_MAX) begin
          ovf_nxt[i] = 1'b1;
        end else begin
          pend_nxt[i] = pend[i] + 1'b1;
        end
      end else if (!event_in[i] && upd_nxt[i]) begin
        pend_nxt[i] = pend[i] - 1'b1;
      end
      if (pend_nxt[i] != '0 || upd_nxt[i]) begin
        idle_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        pend[i] <= '0;
      end
      updates_out   <= '0;
      pend_overflow <= '0;
      idle          <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        pend[i] <= pend_nxt[i];
      end
      updates_out   <= upd_nxt;
      pend_overflow <= ovf_nxt;
      idle          <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_router_op_lut_event_pacer.sv
// tb/tb_router_op_lut_event_pacer.sv - directed self-checking bench for router_op_lut_event_pacer
module tb_router_op_lut_event_pacer;

  localparam int N  = 10;
  localparam int MI = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] event_in;
  logic [N-1:0] updates_out;
  logic [N-1:0] pend_overflow;
  logic         overflow_clr;
  logic         idle;

  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;
  int cyc     = 0;
  int pcnt   [N];
  int lastc  [N];
  int mingap [N];
  int maxgap [N];
  logic [N-1:0] seen;

  router_op_lut_event_pacer #(
    .NUM_EVENTS(N), .PEND_WIDTH(4), .MIN_UPDATE_INTERVAL(MI)
  ) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .updates_out(updates_out),
    .pend_overflow(pend_overflow), .overflow_clr(overflow_clr), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0; lastc[i] = 0; mingap[i] = 1000000; maxgap[i] = 0;
    end
    seen = '0;
  endtask

  // phase tracks the slot counter value that the next edge will see
  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase + 1) % MI;
    cyc++;
    seen |= updates_out;
    for (int i = 0; i < N; i++) begin
      if (updates_out[i]) begin
        if (pcnt[i] > 0) begin
          if (cyc - lastc[i] < mingap[i]) mingap[i] = cyc - lastc[i];
          if (cyc - lastc[i] > maxgap[i]) maxgap[i] = cyc - lastc[i];
        end
        lastc[i] = cyc;
        pcnt[i]++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < MI && phase != p; k++) tick();
  endtask

  initial begin
    reset = 1'b1; event_in = '0; overflow_clr = 1'b0;
    clr_stats();
    #3;
    check("reset_updates", updates_out, 0);
    check("reset_ovf", pend_overflow, 0);
    check("reset_idle", idle, 1);
    @(posedge clk); #1;
    reset = 1'b0; phase = 0;

    // 1: reset while pend[2]=4 remaining and a drain pulse is on the bus
    wait_phase(0);
    event_in[2] = 1'b1; run(5); event_in = '0;
    check("t1_not_idle", idle, 0);
    wait_phase(MI - 1);
    tick();
    check("t1_drain_pulse", updates_out[2], 1);
    reset = 1'b1;
    #1;
    check("t1_async_updates", updates_out, 0);
    check("t1_async_ovf", pend_overflow, 0);
    check("t1_async_idle", idle, 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; phase = 0;
    clr_stats();
    run(3 * MI);
    check("t1_no_pulses", seen, 0);
    check("t1_idle_after", idle, 1);

    // 2: single event at slot 2 drains at the slot-7 edge, five edges later
    clr_stats();
    wait_phase(2);
    event_in[3] = 1'b1; tick(); event_in = '0;
    run(4);
    check("t2_early", pcnt[3], 0);
    tick();
    check("t2_pulse", updates_out, 32'h008);
    check("t2_idle_during", idle, 0);
    tick();
    check("t2_pulse_width", updates_out, 0);
    check("t2_idle_after", idle, 1);

    // 3: five back-to-back events on bit 0
    clr_stats();
    wait_phase(3);
    event_in[0] = 1'b1; run(5); event_in = '0;
    run(6 * MI);
    check("t3_count", pcnt[0], 5);
    check("t3_min_gap", mingap[0], MI);
    check("t3_max_gap", maxgap[0], MI);
    check("t3_ovf", pend_overflow, 0);
    check("t3_idle", idle, 1);

    // 4: twenty events on bit 7 from slot 0 -> saturate at 15, drop 3, emit 17
    clr_stats();
    wait_phase(0);
    event_in[7] = 1'b1; run(20); event_in = '0;
    check("t4_ovf", pend_overflow, 32'h080);
    run(16 * MI);
    check("t4_count", pcnt[7], 17);
    check("t4_min_gap", mingap[7], MI);
    check("t4_other_bits", seen, 32'h080);
    check("t4_idle", idle, 1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    check("t4_clr", pend_overflow, 0);

    // 5a: arrival on the drain edge while pend[5]=1
    clr_stats();
    wait_phase(3);
    event_in[5] = 1'b1; tick(); event_in = '0;
    wait_phase(MI - 1);
    event_in[5] = 1'b1; tick(); event_in = '0;
    check("t5_first_pulse", updates_out, 32'h020);
    run(MI);
    check("t5_second_pulse", updates_out, 32'h020);
    run(2 * MI);
    check("t5_count", pcnt[5], 2);
    check("t5_gap", mingap[5], MI);
    check("t5_idle", idle, 1);

    // 5b: all events together drain in the same slot
    clr_stats();
    wait_phase(4);
    event_in = '1; tick(); event_in = '0;
    run(2);
    check("t5_all_early", seen, 0);
    tick();
    check("t5_all_pulse", updates_out, 32'h3FF);
    tick();
    check("t5_all_width", updates_out, 0);
    check("t5_all_idle", idle, 1);

    // 6: new overflow coincides with clear -> set wins; lone clear afterwards
    wait_phase(0);
    event_in[7] = 1'b1; run(17);
    check("t6_full_no_ovf", pend_overflow, 0);
    overflow_clr = 1'b1; tick();
    event_in = '0; overflow_clr = 1'b0;
    check("t6_set_wins", pend_overflow, 32'h080);
    tick();
    check("t6_sticky", pend_overflow, 32'h080);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    check("t6_clear", pend_overflow, 0);
    run(16 * MI);
    check("t6_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
